// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/mem/writeback sequencing.
// Optional JUMP_EN adds the j instruction (JUMP state, pcSource=10).
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opCode,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regDst,
  output logic             memtoReg,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       pcSource,
  output logic             illegalOp,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instrCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            retire;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memtoReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    illegalOp   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
        if (memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        if (opCode == OP_RTYPE) begin
          state_d = S_EXEC;
        end else if (opCode == OP_LW || opCode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (opCode == OP_BEQ) begin
          state_d = S_BRANCH;
`ifdef JUMP_EN
        end else if (opCode == OP_J) begin
          state_d = S_JUMP;
`endif
        end else begin
          state_d   = S_FETCH;
          illegalOp = 1'b1;
        end
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoReg = 1'b1;
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (memReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
`ifdef JUMP_EN
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    // Reset overrides the FETCH decode so nothing strobes memory
    if (reset) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      regDst      = 1'b0;
      memtoReg    = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      pcSource    = 2'b00;
      illegalOp   = 1'b0;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state      = state_q;
  assign instrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven scoreboard bench for multicycle_control.
// A second CNT_W=2 instance shares stimulus to exercise counter wrap.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode;
  logic       memReady;

  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       regDst, memtoReg, regWrite, aluSrcA, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;
  logic [15:0] instrCount;

  logic       s_pcWrite, s_pcWriteCond, s_iorD, s_memRead, s_memWrite;
  logic       s_irWrite, s_regDst, s_memtoReg, s_regWrite, s_aluSrcA;
  logic       s_illegalOp;
  logic [1:0] s_aluSrcB, s_aluOp, s_pcSource;
  logic [3:0] s_state;
  logic [1:0] s_instrCount;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memtoReg(memtoReg), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .illegalOp(illegalOp), .state(state),
    .instrCount(instrCount)
  );

  multicycle_control #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
    .pcWrite(s_pcWrite), .pcWriteCond(s_pcWriteCond), .iorD(s_iorD),
    .memRead(s_memRead), .memWrite(s_memWrite), .irWrite(s_irWrite),
    .regDst(s_regDst), .memtoReg(s_memtoReg), .regWrite(s_regWrite),
    .aluSrcA(s_aluSrcA), .aluSrcB(s_aluSrcB), .aluOp(s_aluOp),
    .pcSource(s_pcSource), .illegalOp(s_illegalOp), .state(s_state),
    .instrCount(s_instrCount)
  );

  // ctl bits: pcW pcWC iorD mRd mWr irW rDst m2r rW aSA aSB[2] aOp[2] pSrc[2]
  localparam logic [15:0] C_RST  = 16'h0000;
  localparam logic [15:0] C_F0   = 16'h1010;
  localparam logic [15:0] C_F1   = 16'h9410;
  localparam logic [15:0] C_DEC  = 16'h0030;
  localparam logic [15:0] C_MA   = 16'h0060;
  localparam logic [15:0] C_MRD  = 16'h3000;
  localparam logic [15:0] C_MWB  = 16'h0180;
  localparam logic [15:0] C_MWR  = 16'h2800;
  localparam logic [15:0] C_EX   = 16'h0048;
  localparam logic [15:0] C_RWB  = 16'h0280;
  localparam logic [15:0] C_BR   = 16'h4045;
  localparam logic [15:0] C_JMP  = 16'h8002;

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] IL = 6'b001000;
  localparam logic [5:0] JJ = 6'b000010;

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [64];
  int   n = 0;
  vec_t sbq [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [15:0] ctl,
                     input logic ill, input logic [15:0] cnt);
    tbl[n] = '{r, op, rdy, st, ctl, ill, cnt};
    n++;
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp, input int idx);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    logic [15:0] ctl;
    @(negedge clk);
    reset = v.r;
    opCode = v.op;
    memReady = v.rdy;
    sbq.push_back(v);
    #2;
    e = sbq.pop_front();
    ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
           regDst, memtoReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};
    chk("state", {12'd0, state}, {12'd0, e.st}, idx);
    chk("ctl", ctl, e.ctl, idx);
    chk("illegalOp", {15'd0, illegalOp}, {15'd0, e.ill}, idx);
    chk("instrCount", instrCount, e.cnt, idx);
    chk("cnt_wrap2", {14'd0, s_instrCount}, {14'd0, e.cnt[1:0]}, idx);
  endtask

  task automatic hs(input logic r, input logic [5:0] op, input logic rdy,
                    input logic [3:0] st, input logic [15:0] ctl,
                    input logic ill, input logic [15:0] cnt, input int idx);
    vec_t v;
    v = '{r, op, rdy, st, ctl, ill, cnt};
    step(v, idx);
  endtask

  initial begin
    int jc;
    int waits;
    reset = 1'b1;
    opCode = RT;
    memReady = 1'b1;
    @(posedge clk);

    add(1, RT, 1, 0, C_RST, 0, 0);
    add(0, RT, 1, 0, C_F1,  0, 0);
    add(0, RT, 1, 1, C_DEC, 0, 0);
    add(0, RT, 0, 6, C_EX,  0, 0);
    add(0, RT, 1, 7, C_RWB, 0, 0);
    add(0, LW, 0, 0, C_F0,  0, 1);
    add(0, LW, 1, 0, C_F1,  0, 1);
    add(0, LW, 0, 1, C_DEC, 0, 1);
    add(0, LW, 1, 2, C_MA,  0, 1);
    add(0, LW, 0, 3, C_MRD, 0, 1);
    add(0, LW, 0, 3, C_MRD, 0, 1);
    add(0, LW, 1, 3, C_MRD, 0, 1);
    add(0, LW, 0, 4, C_MWB, 0, 1);
    add(0, SW, 1, 0, C_F1,  0, 2);
    add(0, SW, 1, 1, C_DEC, 0, 2);
    add(0, SW, 1, 2, C_MA,  0, 2);
    add(0, SW, 1, 5, C_MWR, 0, 2);
    add(0, BQ, 1, 0, C_F1,  0, 3);
    add(0, BQ, 1, 1, C_DEC, 0, 3);
    add(0, BQ, 1, 8, C_BR,  0, 3);
    add(0, IL, 1, 0, C_F1,  0, 4);
    add(0, IL, 1, 1, C_DEC, 1, 4);
    add(0, SW, 1, 0, C_F1,  0, 4);
    add(0, SW, 1, 1, C_DEC, 0, 4);
    add(0, SW, 0, 2, C_MA,  0, 4);
    add(0, SW, 0, 5, C_MWR, 0, 4);
    add(0, SW, 1, 5, C_MWR, 0, 4);
    add(0, JJ, 1, 0, C_F1,  0, 5);
`ifdef JUMP_EN
    add(0, JJ, 1, 1, C_DEC, 0, 5);
    add(0, JJ, 1, 9, C_JMP, 0, 5);
    jc = 6;
`else
    add(0, JJ, 1, 1, C_DEC, 1, 5);
    jc = 5;
`endif
    add(0, LW, 1, 0, C_F1,  0, 16'(jc));
    add(0, LW, 1, 1, C_DEC, 0, 16'(jc));
    add(1, LW, 1, 2, C_RST, 0, 16'(jc));
    add(1, LW, 1, 0, C_RST, 0, 0);
    add(1, IL, 1, 0, C_RST, 0, 0);
    add(0, BQ, 1, 0, C_F1,  0, 0);
    add(0, BQ, 1, 1, C_DEC, 0, 0);
    add(0, BQ, 1, 8, C_BR,  0, 0);
    add(0, BQ, 0, 0, C_F0,  0, 1);

    for (int i = 0; i < n; i++) step(tbl[i], i);

    // lw with a random MEMRD stall length
    waits = int'($urandom_range(1, 4));
    hs(0, LW, 1, 0, C_F1,  0, 1, 100);
    hs(0, LW, 1, 1, C_DEC, 0, 1, 101);
    hs(0, LW, 1, 2, C_MA,  0, 1, 102);
    for (int k = 0; k < waits; k++) hs(0, LW, 0, 3, C_MRD, 0, 1, 103 + k);
    hs(0, LW, 1, 3, C_MRD, 0, 1, 110);
    hs(0, LW, 0, 4, C_MWB, 0, 1, 111);
    hs(0, RT, 0, 0, C_F0,  0, 2, 112);

    // reset during a MEMRD wait abandons the load
    hs(0, LW, 1, 0, C_F1,  0, 2, 120);
    hs(0, LW, 1, 1, C_DEC, 0, 2, 121);
    hs(0, LW, 0, 2, C_MA,  0, 2, 122);
    hs(0, LW, 0, 3, C_MRD, 0, 2, 123);
    hs(1, LW, 1, 3, C_RST, 0, 2, 124);
    hs(0, RT, 1, 0, C_F1,  0, 0, 125);
    hs(0, RT, 1, 1, C_DEC, 0, 0, 126);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
